// File: rtl/mmio_gpio.sv
// mmio_gpio: memory-mapped GPIO peripheral for the rv32i data bus.
//   N_LEDS 32-bit LED registers, N_KEYS debounced keys with sticky
//   rising-edge flags, per-key interrupt enables and a level irq.
//   Optional macro GPIO_FALL_EDGE_EN adds the KEY_FALL register (index 11)
//   and lets falling edges raise irq as well.
//
// Ports:
//   clk    in   system clock, all state on the rising edge
//   rst    in   synchronous active-high reset
//   we     in   write strobe
//   re     in   read strobe
//   addr   in   [ADDR_W-1:0] word address
//   wdata  in   [31:0] write data
//   rdata  out  [31:0] registered read data (holds while re=0)
//   key    in   [N_KEYS-1:0] raw asynchronous keys
//   led    out  [N_LEDS*32-1:0] LED registers, LED_i at [32i+31:32i]
//   irq    out  interrupt request, level
//
// Register map: 0..N_LEDS-1 LED_i (R/W), 8 KEY_STATE (RO), 9 KEY_RISE (W1C),
//   10 KEY_IE (R/W), 11 KEY_FALL (W1C, optional); others read 0.
module mmio_gpio #(
  parameter int N_LEDS     = 2,
  parameter int N_KEYS     = 4,
  parameter int DEB_CYCLES = 4,
  parameter int ADDR_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  input  logic [N_KEYS-1:0]     key,
  output logic [N_LEDS*32-1:0]  led,
  output logic                  irq
);

  localparam logic [ADDR_W-1:0] A_STATE = ADDR_W'(8);
  localparam logic [ADDR_W-1:0] A_RISE  = ADDR_W'(9);
  localparam logic [ADDR_W-1:0] A_IE    = ADDR_W'(10);
`ifdef GPIO_FALL_EDGE_EN
  localparam logic [ADDR_W-1:0] A_FALL  = ADDR_W'(11);
`endif
  localparam logic [16:0]       DEB_LIM = 17'(DEB_CYCLES);

  logic [N_LEDS-1:0][31:0]  led_q, led_d;
  logic [N_KEYS-1:0]        s1_q, s1_d, s2_q, s2_d;
  logic [N_KEYS-1:0]        stable_q, stable_d;
  logic [N_KEYS-1:0][15:0]  cnt_q, cnt_d;
  logic [N_KEYS-1:0]        rise_q, rise_d;
  logic [N_KEYS-1:0]        ie_q, ie_d;
  logic [31:0]              rdata_q, rdata_d;
  logic                     irq_q, irq_d;
  logic [31:0]              rd_val;
  logic [N_KEYS-1:0]        rose;
`ifdef GPIO_FALL_EDGE_EN
  logic [N_KEYS-1:0]        fall_q, fall_d;
  logic [N_KEYS-1:0]        fell;
`endif

  always_comb begin
    led_d    = led_q;
    s1_d     = key;
    s2_d     = s1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    ie_d     = ie_q;
    rdata_d  = rdata_q;
    rd_val   = '0;

    // Debounce: count consecutive cycles where the synchronised level
    // differs from the accepted one; any agreement restarts the count.
    for (int unsigned k = 0; k < N_KEYS; k++) begin
      if (s2_q[k] == stable_q[k]) begin
        cnt_d[k] = '0;
      end else if (({1'b0, cnt_q[k]} + 17'd1) == DEB_LIM) begin
        stable_d[k] = s2_q[k];
        cnt_d[k]    = '0;
      end else begin
        cnt_d[k] = cnt_q[k] + 16'd1;
      end
    end

    // Edge flags: a new event wins over a same-cycle W1C clear.
    rose   = stable_d & ~stable_q;
    rise_d = rise_q;
    if (we && addr == A_RISE) rise_d = rise_q & ~wdata[N_KEYS-1:0];
    rise_d = rise_d | rose;
`ifdef GPIO_FALL_EDGE_EN
    fell   = stable_q & ~stable_d;
    fall_d = fall_q;
    if (we && addr == A_FALL) fall_d = fall_q & ~wdata[N_KEYS-1:0];
    fall_d = fall_d | fell;
    irq_d  = |((rise_q | fall_q) & ie_q);
`else
    irq_d  = |(rise_q & ie_q);
`endif

    for (int unsigned i = 0; i < N_LEDS; i++) begin
      if (we && addr == ADDR_W'(i)) led_d[i] = wdata;
    end
    if (we && addr == A_IE) ie_d = wdata[N_KEYS-1:0];

    // Read mux uses pre-edge contents, giving read-before-write.
    for (int unsigned i = 0; i < N_LEDS; i++) begin
      if (addr == ADDR_W'(i)) rd_val = led_q[i];
    end
    if (addr == A_STATE) rd_val[N_KEYS-1:0] = stable_q;
    if (addr == A_RISE)  rd_val[N_KEYS-1:0] = rise_q;
    if (addr == A_IE)    rd_val[N_KEYS-1:0] = ie_q;
`ifdef GPIO_FALL_EDGE_EN
    if (addr == A_FALL)  rd_val[N_KEYS-1:0] = fall_q;
`endif
    if (re) rdata_d = rd_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q    <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      rise_q   <= '0;
      ie_q     <= '0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
`ifdef GPIO_FALL_EDGE_EN
      fall_q   <= '0;
`endif
    end else begin
      led_q    <= led_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      ie_q     <= ie_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
`ifdef GPIO_FALL_EDGE_EN
      fall_q   <= fall_d;
`endif
    end
  end

  assign led   = led_q;
  assign rdata = rdata_q;
  assign irq   = irq_q;

endmodule

// File: tb/tb_mmio_gpio.sv
// Scoreboard bench for mmio_gpio: a driver applies one bus/key vector per
// cycle, advances a behavioural model and queues the expected outputs; a
// monitor pops one entry after every rising edge and compares.
module tb_mmio_gpio;
  localparam int N_LEDS = 2;
  localparam int N_KEYS = 4;
  localparam int DEB    = 4;
  localparam int ADDR_W = 4;
  localparam logic [31:0] KMASK = (32'd1 << N_KEYS) - 32'd1;

  logic                 clk = 1'b0;
  logic                 rst, we, re;
  logic [ADDR_W-1:0]    addr;
  logic [31:0]          wdata, rdata;
  logic [N_KEYS-1:0]    key;
  logic [N_LEDS*32-1:0] led;
  logic                 irq;

  mmio_gpio #(.N_LEDS(N_LEDS), .N_KEYS(N_KEYS), .DEB_CYCLES(DEB), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .we(we), .re(re), .addr(addr), .wdata(wdata),
    .rdata(rdata), .key(key), .led(led), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N_LEDS*32-1:0] led;
    logic                 irq;
    logic [31:0]          rdata;
    bit                   is_rd;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;

  // Reference model state.
  logic [31:0] m_led [N_LEDS];
  logic [31:0] m_stable, m_rise, m_fall, m_ie, m_rdata;
  logic        m_irq;
  logic [N_KEYS-1:0] smp[$];  // raw key samples, one per non-reset edge

  task automatic model_reset();
    for (int i = 0; i < N_LEDS; i++) m_led[i] = '0;
    m_stable = '0; m_rise = '0; m_fall = '0; m_ie = '0; m_rdata = '0;
    m_irq = 1'b0;
    smp.delete();
  endtask

  function automatic logic [31:0] model_read(input int a);
    if (a < N_LEDS) return m_led[a];
    case (a)
      8:  return m_stable;
      9:  return m_rise;
      10: return m_ie;
`ifdef GPIO_FALL_EDGE_EN
      11: return m_fall;
`endif
      default: return 32'd0;
    endcase
  endfunction

  // One bus cycle: drive at negedge, then advance the model to the edge.
  task automatic step(input bit r, input bit w, input bit rd, input int a,
                      input logic [31:0] d, input logic [N_KEYS-1:0] k);
    logic [31:0] rv, ns, rose, fell;
    logic        irq_n;
    exp_t        e;
    int          sz;
    bit          all_diff;
    @(negedge clk);
    rst = r; we = w; re = rd; addr = a[ADDR_W-1:0]; wdata = d; key = k;
    if (r) begin
      model_reset();
    end else begin
      rv    = model_read(a);
      irq_n = |((m_rise | m_fall) & m_ie);
      smp.push_back(k);
      if (smp.size() > DEB + 2) void'(smp.pop_front());
      // The accepted level flips once DEB consecutive samples, taken two
      // edges or more ago, all disagree with it.
      ns = m_stable;
      sz = smp.size();
      if (sz >= DEB + 2) begin
        for (int b = 0; b < N_KEYS; b++) begin
          all_diff = 1'b1;
          for (int j = 0; j < DEB; j++)
            if (smp[sz-3-j][b] == m_stable[b]) all_diff = 1'b0;
          if (all_diff) ns[b] = ~m_stable[b];
        end
      end
      rose = ns & ~m_stable;
      fell = m_stable & ~ns;
      if (w && a == 9) m_rise = m_rise & ~d;
      m_rise = (m_rise | rose) & KMASK;
`ifdef GPIO_FALL_EDGE_EN
      if (w && a == 11) m_fall = m_fall & ~d;
      m_fall = (m_fall | fell) & KMASK;
`else
      if (fell != 32'd0) m_fall = '0;
`endif
      if (rd) m_rdata = rv;
      if (w && a < N_LEDS) m_led[a] = d;
      if (w && a == 10) m_ie = d & KMASK;
      m_stable = ns;
      m_irq    = irq_n;
    end
    for (int i = 0; i < N_LEDS; i++) e.led[32*i +: 32] = m_led[i];
    e.irq   = m_irq;
    e.rdata = m_rdata;
    e.is_rd = rd || r;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input logic [N_KEYS-1:0] k);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 32'd0, k);
  endtask

  // Monitor: one expectation per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        tests++;
        if (led !== e.led) begin
          fails++;
          $display("FAIL led got %h want %h at %0t", led, e.led, $time);
        end
        tests++;
        if (irq !== e.irq) begin
          fails++;
          $display("FAIL irq got %b want %b at %0t", irq, e.irq, $time);
        end
        if (e.is_rd) begin
          tests++;
          if (rdata !== e.rdata) begin
            fails++;
            $display("FAIL rdata got %h want %h at %0t", rdata, e.rdata, $time);
          end
        end
      end
    end
  end

  initial begin
    logic [N_KEYS-1:0] kv;
    rst = 1'b1; we = 1'b0; re = 1'b0; addr = '0; wdata = '0; key = '0;
    // Reset and idle reads.
    step(1, 0, 0, 0, 32'd0, 4'h0);
    step(1, 1, 1, 1, 32'hFFFF_FFFF, 4'h0);
    idle(2, 4'h0);
    step(0, 0, 1, 0, 32'd0, 4'h0);
    step(0, 0, 1, 8, 32'd0, 4'h0);
    step(0, 0, 1, 9, 32'd0, 4'h0);
    step(0, 0, 1, 10, 32'd0, 4'h0);
    // LED write/read, unmapped read, read-before-write.
    step(0, 1, 0, 1, 32'hDEAD_BEEF, 4'h0);
    step(0, 0, 1, 1, 32'd0, 4'h0);
    step(0, 0, 1, 5, 32'd0, 4'h0);
    step(0, 1, 1, 0, 32'h1234_5678, 4'h0);
    step(0, 0, 1, 0, 32'd0, 4'h0);
    step(0, 1, 0, 11, 32'hFFFF_FFFF, 4'h0);
    step(0, 0, 1, 11, 32'd0, 4'h0);
    // Short key pulse must not propagate.
    idle(3, 4'h1);
    idle(6, 4'h0);
    step(0, 0, 1, 8, 32'd0, 4'h0);
    step(0, 0, 1, 9, 32'd0, 4'h0);
    // Interrupt flow on key[0].
    step(0, 1, 0, 10, 32'h0000_0001, 4'h0);
    for (int i = 0; i < 9; i++) step(0, 0, 1, 8, 32'd0, 4'h1);
    step(0, 0, 1, 9, 32'd0, 4'h1);
    step(0, 1, 0, 9, 32'h0000_0001, 4'h1);
    idle(2, 4'h1);
    step(0, 0, 1, 9, 32'd0, 4'h1);
    idle(8, 4'h0);
    // Set/clear collision on key[1]: sixth edge of the hold is the set edge.
    idle(5, 4'h2);
    step(0, 1, 0, 9, 32'h0000_0002, 4'h2);
    step(0, 0, 1, 9, 32'd0, 4'h2);
    step(0, 1, 0, 9, 32'h0000_0002, 4'h2);
    step(0, 0, 1, 9, 32'd0, 4'h2);
    // Reset mid-debounce on key[2].
    idle(4, 4'h4);
    step(1, 0, 0, 0, 32'd0, 4'h4);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 8, 32'd0, 4'h4);
    // Randomised traffic with slowly changing keys.
    kv = '0;
    for (int i = 0; i < 600; i++) begin
      int a;
      if ($urandom_range(0, 7) == 0) kv[$urandom_range(0, N_KEYS-1)] ^= 1'b1;
      a = $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) a = $urandom_range(8, 11);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1, a,
           ($urandom_range(0, 1) == 1) ? $urandom : $urandom & KMASK, kv);
    end
    idle(2, kv);
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
